pixel_fetch: RTL and testbench
==============================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter FB_BASE, 24'h000000, framebuffer word address of line 0.
REQ-002 Parameter FIFO_DEPTH, 16, word FIFO depth (power of two, >=4).
REQ-003 clk  in  1  pixel clock (74.25 MHz, same as timing generator).
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 x, y  in  16 each  beam position from timing generator (0-based in active region).
REQ-006 hsync, vsync, hprep, vprep, visible  in  1 each  timing generator outputs, same cycle as x/y.
REQ-007 mem_req  out  1  read request; mem_addr  out  24  word address.
REQ-008 mem_ack  in  1  single-cycle acknowledge; mem_data  in  32  read word, valid only when mem_ack=1.
REQ-009 pix_rgb  out  16  RGB565 pixel; out_hsync, out_vsync, out_de  out  1 each  delayed sync/data-enable.
REQ-010 underflow  out  1  sticky FIFO-underflow flag.

Function
REQ-011 Words per line = 640 (1280 px, two px/word: low half = even x, high half = odd x).
REQ-012 Line address = FB_BASE + y*640, computed as (y<<9)+(y<<7), 24-bit, wrap modulo 2^24.
REQ-013 FSM states IDLE, FETCH, WAIT, DRAIN.
REQ-014 hprep rising edge (hprep=1, previous cycle 0): FIFO flushed, word counter=0, line address latched from current y, state -> FETCH (from IDLE/FETCH) or DRAIN (from WAIT).
REQ-015 FETCH: if fifo_count + 1 <= FIFO_DEPTH (outstanding included) and word counter < 640, assert mem_req with mem_addr = line address + word counter; -> WAIT.
REQ-016 WAIT: mem_req and mem_addr held stable until mem_ack; on ack push mem_data, counter+1, -> FETCH, or -> IDLE if counter reaches 640.
REQ-017 DRAIN: mem_req held; on mem_ack data discarded (no push), -> FETCH with new line address, counter=0.
REQ-018 At most one outstanding request at any time.
REQ-019 Output latency exactly 1 clock: out_hsync/out_vsync/out_de registered from hsync/vsync/visible.
REQ-020 When visible=1: pix_rgb <= x[0] ? head[31:16] : head[15:0]; FIFO pops when x[0]=1.
REQ-021 visible=1 with FIFO empty: pix_rgb <= 0, no pop, underflow <= 1 (stays set until reset).
REQ-022 visible=0: pix_rgb <= 0, no pop.
REQ-023 Simultaneous push and pop: fifo_count unchanged, data ordered.
REQ-024 Flush (REQ-014) has priority over a simultaneous push or pop.
REQ-025 vprep and vsync ignored by the FSM; fetching driven by hprep only.

Reset
REQ-026 reset=0 asynchronously forces: state IDLE, FIFO empty, counter 0, mem_req 0, mem_addr 0, pix_rgb 0, out_hsync/out_vsync/out_de 0, underflow 0.
REQ-027 reset asserted mid-request abandons the request; a late mem_ack after reset release while IDLE is ignored.

Structure
REQ-028 Shared package holds H_ACTIVE_PIXELS (1280), WORDS_PER_LINE (640), FB address width (24), state encodings.
REQ-029 Sub-module pixel_fifo: synchronous FIFO, push/pop/flush, count, full/empty, same clk/reset.

Verification
REQ-030 Reset release, hprep edge with y=0, mem_ack 2 cycles after each req -> first mem_addr=FB_BASE, 640 requests ending at FB_BASE+639, no underflow.
REQ-031 y=3 line, FB_BASE=24'h001000 -> first mem_addr=24'h001780.
REQ-032 mem_data=32'hBEEF_1234 at word 0 -> pix_rgb=16'h1234 cycle after x=0, 16'hBEEF cycle after x=1; out_de=1 aligned.
REQ-033 mem_ack withheld 300 cycles -> pix_rgb=0 during visible, underflow=1 and stays 1 after ack resumes.
REQ-034 hprep edge while in WAIT -> next ack's data not pushed, next req addr = new line base.
REQ-035 reset=0 asserted while mem_req=1 -> mem_req=0 same cycle (asynchronous), FIFO count 0.

Source files
------------

// File: rtl/pixel_fetch_pkg.sv
// Shared constants, types and address helper for the framebuffer line fetcher.
package pixel_fetch_pkg;

  localparam int H_ACTIVE_PIXELS = 1280;
  localparam int WORDS_PER_LINE  = H_ACTIVE_PIXELS / 2;
  localparam int FB_AW           = 24;
  localparam int WCNT_W          = 10;

  typedef logic [FB_AW-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // base + y*640 as two shifts; the sum wraps naturally at 24 bits
  function automatic fb_addr_t line_base(fb_addr_t base, logic [15:0] y);
    fb_addr_t yy;
    yy = fb_addr_t'(y);
    return base + (yy << 9) + (yy << 7);
  endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// Word-read memory port: one request held until a single-cycle acknowledge.
interface pixel_fetch_if;
  import pixel_fetch_pkg::*;

  logic        mem_req;
  fb_addr_t    mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;

  modport master (output mem_req, mem_addr, input mem_ack, mem_data);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/pixel_fetch_fifo.sv
// Synchronous word FIFO with flush; head is the oldest entry (show-ahead).
module pixel_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  // flush wins over anything arriving in the same cycle
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_fetch.sv
// Fetches one framebuffer line per hprep edge into a word FIFO and streams
// RGB565 pixels (two per word) aligned one clock behind the timing inputs.
module pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter fb_addr_t FB_BASE    = 24'h000000,
  parameter int       FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   x,
  input  logic [15:0]   y,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hprep,
  input  logic          vprep,
  input  logic          visible,
  pixel_fetch_if.master mem,
  output logic [15:0]   pix_rgb,
  output logic          out_hsync,
  output logic          out_vsync,
  output logic          out_de,
  output logic          underflow
);

  localparam int                AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0]     DEPTH_C   = (AW+2)'(FIFO_DEPTH);
  localparam logic [AW+1:0]     CNT_ONE   = (AW+2)'(1);
  localparam logic [WCNT_W-1:0] WORDS     = WCNT_W'(WORDS_PER_LINE);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_LINE - 1);

  fetch_state_e      state;
  logic [WCNT_W-1:0] wcnt;
  fb_addr_t          line_addr;
  logic              hprep_q, hprep_rise;
  logic              push, pop, flush, can_issue;
  logic [31:0]       head;
  logic [AW:0]       fifo_count;
  logic              fifo_full, fifo_empty;
  logic              unused_in;

  assign unused_in  = ^{vprep, x[15:1], fifo_full};
  assign hprep_rise = hprep & ~hprep_q;
  assign flush      = hprep_rise;
  assign push       = (state == WAIT) & mem.mem_ack & ~hprep_rise;
  assign pop        = visible & x[0] & ~fifo_empty;
  // only one request can be in flight, so the slot it will fill is fifo_count+1
  assign can_issue  = (({1'b0, fifo_count} + CNT_ONE) <= DEPTH_C) && (wcnt < WORDS);

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (mem.mem_data),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      line_addr    <= '0;
      hprep_q      <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      hprep_q <= hprep;
      if (hprep_rise) begin
        wcnt      <= '0;
        line_addr <= line_base(FB_BASE, y);
        // a request still in flight must be retired before the new line starts
        if ((state == WAIT || state == DRAIN) && !mem.mem_ack) begin
          state <= DRAIN;
        end else begin
          state       <= FETCH;
          mem.mem_req <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: ;
          FETCH:
            if (can_issue) begin
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= line_addr + fb_addr_t'(wcnt);
              state        <= WAIT;
            end
          WAIT:
            if (mem.mem_ack) begin
              mem.mem_req <= 1'b0;
              wcnt        <= wcnt + WCNT_W'(1);
              state       <= (wcnt == LAST_WORD) ? IDLE : FETCH;
            end
          DRAIN:
            if (mem.mem_ack) begin
              mem.mem_req <= 1'b0;
              wcnt        <= '0;
              state       <= FETCH;
            end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_rgb   <= '0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_de    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_hsync <= hsync;
      out_vsync <= vsync;
      out_de    <= visible;
      if (visible && !fifo_empty) pix_rgb <= x[0] ? head[31:16] : head[15:0];
      else                        pix_rgb <= '0;
      if (visible && fifo_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: pixel scoreboard, auto-acking memory model, line
// address table and hand sequences for drain, underflow and reset corners.
module tb_pixel_fetch;
  import pixel_fetch_pkg::*;

  localparam logic [23:0] BASE = 24'h001000;

  logic        clk = 1'b0, reset = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        hsync = 0, vsync = 0, hprep = 0, vprep = 0, visible = 0;
  logic [15:0] pix_rgb;
  logic        out_hsync, out_vsync, out_de, underflow;

  pixel_fetch_if mem_bus();

  pixel_fetch #(.FB_BASE(BASE), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .hprep(hprep), .vprep(vprep), .visible(visible), .mem(mem_bus.master),
    .pix_rgb(pix_rgb), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .out_de(out_de), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic hs; logic vs; logic de; logic [15:0] pix; logic chk_pix; } exp_t;
  typedef struct { logic [15:0] y; logic [23:0] a0; } vec_t;

  exp_t        sb[$];
  logic [23:0] ack_log[$];
  int          total = 0, bad = 0;
  logic        hold = 0, force_ack = 0, prev_req = 0, prev_ack = 0;
  int          ack_wait = 0;
  logic [23:0] prev_addr = '0;
  logic [23:0] word0_addr = 24'hFFFFFF;
  logic [23:0] cur_base = BASE;

  function automatic logic [31:0] data_fn(logic [23:0] a);
    if (a == word0_addr) return 32'hBEEF_1234;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [15:0] exp_pix(logic [15:0] xx);
    logic [31:0] w;
    w = data_fn(cur_base + 24'(xx[15:1]));
    return xx[0] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory model: ack two cycles into a request unless held
  task automatic respond();
    if (!reset) begin
      mem_bus.mem_ack = 1'b0; ack_wait = 0; prev_req = 0; prev_ack = 0;
      return;
    end
    if (prev_ack) chk("req_drop_after_ack", 32'(mem_bus.mem_req), 0);
    else if (prev_req && mem_bus.mem_req) chk("addr_stable", mem_bus.mem_addr, prev_addr);
    prev_req = mem_bus.mem_req;
    prev_addr = mem_bus.mem_addr;
    mem_bus.mem_ack = 1'b0;
    if (force_ack) begin
      mem_bus.mem_ack = 1'b1; mem_bus.mem_data = 32'hDEAD_DEAD; force_ack = 0;
    end else if (mem_bus.mem_req && !hold) begin
      ack_wait++;
      if (ack_wait >= 2) begin
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_data = data_fn(mem_bus.mem_addr);
        ack_log.push_back(mem_bus.mem_addr);
        ack_wait = 0;
      end
    end else if (!mem_bus.mem_req) ack_wait = 0;
    prev_ack = mem_bus.mem_ack;
  endtask

  // pm: 0 = pixel from line model, 1 = pixel must be zero, 2 = pixel unchecked
  task automatic cyc(logic vis, logic [15:0] xx, logic hs, logic vs, logic hp,
                     logic [15:0] yy, int pm);
    exp_t e;
    visible = vis; x = xx; hsync = hs; vsync = vs; hprep = hp; y = yy; vprep = hs;
    e.hs = reset & hs;
    e.vs = reset & vs;
    e.de = reset & vis;
    e.pix = (reset && vis && pm == 0) ? exp_pix(xx) : 16'h0;
    e.chk_pix = (pm != 2);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("out_hsync", 32'(out_hsync), 32'(e.hs));
    chk("out_vsync", 32'(out_vsync), 32'(e.vs));
    chk("out_de", 32'(out_de), 32'(e.de));
    if (e.chk_pix) chk("pix_rgb", 32'(pix_rgb), 32'(e.pix));
    respond();
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 16'h0, 0, 0, 0, y, 0);
  endtask

  task automatic wait_acks(int n, int budget);
    int k = 0;
    while (ack_log.size() < n && k < budget) begin idle(1); k++; end
    if (ack_log.size() < n) chk("ack_timeout", 32'(ack_log.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   s;
    logic seq_ok;
    tbl[0] = '{16'd0,     24'h001000};
    tbl[1] = '{16'd1,     24'h001280};
    tbl[2] = '{16'd3,     24'h001780};
    tbl[3] = '{16'd719,   24'h071580};
    tbl[4] = '{16'hFFFF,  24'h800D80};
    mem_bus.mem_ack = 1'b0; mem_bus.mem_data = '0;

    // reset holds every output low regardless of inputs
    hsync = 1; vsync = 1; visible = 1; x = 16'd1; hprep = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_bus.mem_req), 0);
    chk("rst_mem_addr", mem_bus.mem_addr, 0);
    chk("rst_pix", 32'(pix_rgb), 0);
    chk("rst_hsync", 32'(out_hsync), 0);
    chk("rst_vsync", 32'(out_vsync), 0);
    chk("rst_de", 32'(out_de), 0);
    chk("rst_underflow", 32'(underflow), 0);
    hsync = 0; vsync = 0; visible = 0; x = 0; hprep = 0;
    reset = 1;
    idle(4);
    chk("idle_no_req", 32'(mem_bus.mem_req), 0);

    // full line y=0: 640 sequential reads, every pixel scoreboarded
    word0_addr = BASE; cur_base = BASE; ack_log.delete();
    cyc(0, 0, 0, 0, 1, 16'd0, 0);
    idle(60);
    for (int px = 0; px < 1280; px += 2) begin
      cyc(1, 16'(px), 0, 0, 0, 16'd0, 0);
      cyc(1, 16'(px + 1), 0, 0, 0, 16'd0, 0);
      cyc(0, 0, 1, 0, 0, 16'd0, 0);
      cyc(0, 0, 0, px[7], 0, 16'd0, 0);
    end
    idle(10);
    chk("line_req_count", 32'(ack_log.size()), 640);
    if (ack_log.size() == 640) begin
      chk("line_first_addr", ack_log[0], BASE);
      chk("line_last_addr", ack_log[639], BASE + 24'd639);
      seq_ok = 1;
      for (int i = 0; i < 640; i++) if (ack_log[i] != BASE + 24'(i)) seq_ok = 0;
      chk("line_addr_seq", 32'(seq_ok), 1);
    end
    chk("line_underflow", 32'(underflow), 0);
    chk("line_done_idle", 32'(mem_bus.mem_req), 0);
    word0_addr = 24'hFFFFFF;

    // line base table: first two words after an hprep edge
    for (int i = 0; i < 5; i++) begin
      idle(60);
      s = ack_log.size();
      cyc(0, 0, 0, 0, 1, tbl[i].y, 0);
      wait_acks(s + 2, 40);
      if (ack_log.size() >= s + 2) begin
        chk("line_addr_w0", ack_log[s], tbl[i].a0);
        chk("line_addr_w1", ack_log[s+1], tbl[i].a0 + 24'd1);
      end
    end

    // hprep edge while a request is outstanding: drained, data discarded
    idle(60);
    hold = 1; s = ack_log.size();
    cyc(0, 0, 0, 0, 1, 16'd5, 0);
    idle(5);
    chk("wait_req", 32'(mem_bus.mem_req), 1);
    chk("wait_addr", mem_bus.mem_addr, 24'h001C80);
    cyc(0, 0, 0, 0, 1, 16'd7, 0);
    idle(3);
    chk("drain_req_held", 32'(mem_bus.mem_req), 1);
    chk("drain_addr_held", mem_bus.mem_addr, 24'h001C80);
    hold = 0;
    wait_acks(s + 2, 40);
    if (ack_log.size() >= s + 2) begin
      chk("drain_old_addr", ack_log[s], 24'h001C80);
      chk("drain_new_base", ack_log[s+1], 24'h002180);
    end
    idle(30);
    cur_base = 24'h002180;
    for (int i = 0; i < 4; i++) cyc(1, 16'(i), 0, 0, 0, 16'd7, 0);
    chk("no_underflow_yet", 32'(underflow), 0);

    // acks withheld 300 cycles: blank pixels, sticky underflow
    hold = 1;
    cyc(0, 0, 0, 0, 1, 16'd2, 0);
    for (int i = 0; i < 300; i++) begin
      if (i >= 20 && i < 60) cyc(1, 16'(i - 20), 0, 0, 0, 16'd2, 1);
      else idle(1);
    end
    chk("underflow_set", 32'(underflow), 1);
    hold = 0;
    idle(40);
    chk("underflow_sticky", 32'(underflow), 1);
    cur_base = 24'h001500;
    cyc(1, 0, 0, 0, 0, 16'd2, 0);
    cyc(1, 1, 0, 0, 0, 16'd2, 0);

    // reset during a request, then a stray ack while idle
    hold = 1;
    cyc(0, 0, 0, 0, 1, 16'd4, 0);
    idle(4);
    chk("pre_reset_req", 32'(mem_bus.mem_req), 1);
    #2 reset = 0;
    #1;
    chk("async_req_drop", 32'(mem_bus.mem_req), 0);
    chk("reset_fifo_count", 32'(dut.u_fifo.count), 0);
    chk("reset_underflow", 32'(underflow), 0);
    idle(2);
    reset = 1; hold = 0;
    force_ack = 1;
    idle(6);
    chk("late_ack_ignored", 32'(mem_bus.mem_req), 0);
    cur_base = 24'h001A00;
    cyc(0, 0, 0, 0, 1, 16'd4, 0);
    idle(30);
    cyc(1, 0, 0, 0, 0, 16'd4, 0);
    cyc(1, 1, 0, 0, 0, 16'd4, 0);
    chk("post_reset_underflow", 32'(underflow), 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
